// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD frame scheduler.
package lcd_sched_pkg;

    // Characters in one full-screen frame (16x2 display).
    localparam int unsigned LCD_NCHAR = 32;

    // Display source indices; these also select the character mux input.
    localparam int unsigned SRC_CLOCK     = 0;
    localparam int unsigned SRC_STOPWATCH = 1;
    localparam int unsigned SRC_TIMER     = 2;
    localparam int unsigned SRC_ALARM     = 3;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SEND,
        GAP
    } sched_state_t;

endpackage

// File: rtl/lcd_refresh_timer.sv
// Saturating idle-tick counter; due_o flags that a forced redraw is owed.
module lcd_refresh_timer #(
    parameter int unsigned MAX_COUNT = 500
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic due_o
);

    localparam int unsigned CNT_W = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stop at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables forced refresh entirely.
    assign due_o = (MAX_COUNT != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Arbitrates the 16x2 LCD between display sources and streams one
// 32-character frame per redraw over a valid/ready handshake.
module lcd_frame_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int unsigned NSRC          = 4,
    parameter int unsigned NCHAR         = LCD_NCHAR,
    parameter int unsigned OVL_SRC       = SRC_ALARM,
    parameter int unsigned REFRESH_TICKS = 500,
    parameter int unsigned GAP_TICKS     = 2
) (
    input  logic            clk_1k,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src_toggle,
    input  logic [1:0]      fg_sel,
    input  logic            ovl_req,
    input  logic            char_ready,
    output logic            char_valid,
    output logic [4:0]      char_idx,
    output logic [1:0]      mux_sel,
    output logic            frame_busy,
    output logic            frame_done
);

    localparam logic [4:0]  LAST_IDX = 5'(NCHAR - 1);
    localparam int unsigned GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LAST < 1) ? 1 : $clog2(GAP_LAST + 1);

    sched_state_t     state_q;
    logic [NSRC-1:0]  prev_tog_q, prev_tog_d;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  tog_edge;
    logic [1:0]       cur_src_q;
    logic [1:0]       last_src_q;
    logic             drawn_q;
    logic [4:0]       idx_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [GAP_W-1:0] gap_cnt_q;

    logic [1:0] eff;
    logic       refresh_due;
    logic       start_req;
    logic       gap_last;

    assign eff = ovl_req ? 2'(OVL_SRC) : fg_sel;

    // Request edges and pending set; SETUP drops every request, but an
    // edge landing in that same cycle is OR-ed in after the clear.
    always_comb begin
        prev_tog_d = src_toggle;
        tog_edge   = src_toggle ^ prev_tog_q;
        pending_d  = ((state_q == SETUP) ? '0 : pending_q) | tog_edge;
    end

    // Toggle history and pending-request registers.
    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            prev_tog_q <= '0;
            pending_q  <= '0;
        end else begin
            prev_tog_q <= prev_tog_d;
            pending_q  <= pending_d;
        end
    end

    lcd_refresh_timer #(
        .MAX_COUNT (REFRESH_TICKS)
    ) u_refresh (
        .clk_i  (clk_1k),
        .rst_ni (rst_n),
        .clr_i  (state_q == SETUP),
        .inc_i  ((state_q == IDLE) || (state_q == GAP)),
        .due_o  (refresh_due)
    );

    assign start_req = pending_q[eff] || refresh_due || !drawn_q || (eff != last_src_q);

    // GAP always spends at least one cycle so frame_done has a home.
    assign gap_last = (GAP_TICKS <= 1) || (gap_cnt_q == GAP_W'(GAP_LAST));

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_src_q  <= 2'(SRC_CLOCK);
            last_src_q <= 2'(SRC_CLOCK);
            drawn_q    <= 1'b0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    cur_src_q <= eff;
                    idx_q     <= '0;
                    valid_q   <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (char_ready) begin
                        if (eff != cur_src_q) begin
                            // Ownership moved: finish this handshake, then abort silently.
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= GAP;
                        end else if (idx_q == LAST_IDX) begin
                            valid_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            last_src_q <= cur_src_q;
                            drawn_q    <= 1'b1;
                            gap_cnt_q  <= '0;
                            state_q    <= GAP;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign char_valid = valid_q;
    assign char_idx   = idx_q;
    assign mux_sel    = cur_src_q;
    assign frame_busy = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed testbench for lcd_frame_scheduler with default parameters.
module tb_lcd_frame_scheduler;

    logic       clk_1k;
    logic       rst_n;
    logic [3:0] src_toggle;
    logic [1:0] fg_sel;
    logic       ovl_req;
    logic       char_ready;
    logic       char_valid;
    logic [4:0] char_idx;
    logic [1:0] mux_sel;
    logic       frame_busy;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    // Observation window accumulators (cycle numbers start at 1 per window).
    int         cyc;
    int         w_valid, w_starts, w_done, w_idxerr, w_muxchg, w_busy, w_first_done;
    int         w_start [8];
    logic [1:0] w_mux   [8];
    logic       prev_valid;
    int         exp_idx;
    logic [1:0] cur_mux;

    lcd_frame_scheduler #(
        .NSRC          (4),
        .NCHAR         (32),
        .OVL_SRC       (3),
        .REFRESH_TICKS (500),
        .GAP_TICKS     (2)
    ) dut (
        .clk_1k     (clk_1k),
        .rst_n      (rst_n),
        .src_toggle (src_toggle),
        .fg_sel     (fg_sel),
        .ovl_req    (ovl_req),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_idx   (char_idx),
        .mux_sel    (mux_sel),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    initial clk_1k = 1'b0;
    always #5 clk_1k = ~clk_1k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_watch();
        cyc = 0; w_valid = 0; w_starts = 0; w_done = 0; w_idxerr = 0;
        w_muxchg = 0; w_busy = 0; w_first_done = -1; exp_idx = 0;
        prev_valid = char_valid; cur_mux = mux_sel;
        for (int i = 0; i < 8; i++) begin w_start[i] = -1; w_mux[i] = '0; end
    endtask

    // Records what the DUT does for n cycles, sampled at the falling edge.
    task automatic watch(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_1k);
            cyc++;
            if (frame_busy) w_busy++;
            if (frame_done) begin
                w_done++;
                if (w_first_done < 0) w_first_done = cyc;
            end
            if (char_valid) begin
                w_valid++;
                if (!prev_valid) begin
                    if (w_starts < 8) begin w_start[w_starts] = cyc; w_mux[w_starts] = mux_sel; end
                    w_starts++;
                    exp_idx = 0;
                    cur_mux = mux_sel;
                end
                if (char_idx != exp_idx[4:0]) w_idxerr++;
                if (mux_sel != cur_mux) w_muxchg++;
                if (char_ready) exp_idx++;
            end
            prev_valid = char_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src_toggle = '0; fg_sel = 2'd1; ovl_req = 1'b0; char_ready = 1'b1;
        repeat (3) @(negedge clk_1k);
        tests++; if (char_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", char_valid); end
        tests++; if (char_idx !== 5'd0) begin fails++; $display("FAIL rst_idx: got %0d want 0", char_idx); end
        tests++; if (mux_sel !== 2'd0) begin fails++; $display("FAIL rst_mux: got %0d want 0", mux_sel); end
        tests++; if (frame_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", frame_busy); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", frame_done); end
        rst_n = 1'b1;
        clear_watch();
        watch(1);
        tests++; if ({frame_busy, char_valid} !== 2'b10) begin fails++; $display("FAIL rst_setup: busy,valid got %b want 10", {frame_busy, char_valid}); end
        watch(44);
        tests++; if (w_starts !== 1) begin fails++; $display("FAIL rst_starts: got %0d want 1", w_starts); end
        tests++; if (w_start[0] !== 2) begin fails++; $display("FAIL rst_first_valid: got cycle %0d want 2", w_start[0]); end
        tests++; if (w_valid !== 32) begin fails++; $display("FAIL rst_valid_cycles: got %0d want 32", w_valid); end
        tests++; if (w_idxerr !== 0) begin fails++; $display("FAIL rst_idx_seq: got %0d errors want 0", w_idxerr); end
        tests++; if (w_mux[0] !== 2'd1 || w_muxchg !== 0) begin fails++; $display("FAIL rst_mux_frame: got %0d (chg %0d) want 1", w_mux[0], w_muxchg); end
        tests++; if (w_done !== 1) begin fails++; $display("FAIL rst_done_count: got %0d want 1", w_done); end
        tests++; if (w_first_done !== 34) begin fails++; $display("FAIL rst_done_cycle: got %0d want 34", w_first_done); end
        tests++; if (w_busy !== 33) begin fails++; $display("FAIL rst_busy_cycles: got %0d want 33", w_busy); end
    endtask

    task automatic test_reset_midframe();
        src_toggle[1] = ~src_toggle[1];
        clear_watch();
        watch(12);
        tests++; if (char_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %0b want 1", char_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (char_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: got %0b want 0", char_valid); end
        tests++; if (frame_busy !== 1'b0) begin fails++; $display("FAIL mid_async_busy: got %0b want 0", frame_busy); end
        @(negedge clk_1k);
        rst_n = 1'b1;
        clear_watch();
        watch(45);
        tests++; if (w_starts !== 1 || w_start[0] !== 2) begin fails++; $display("FAIL mid_redraw: got %0d starts at %0d want 1 at 2", w_starts, w_start[0]); end
        tests++; if (w_done !== 1) begin fails++; $display("FAIL mid_done: got %0d want 1", w_done); end
    endtask

    task automatic test_stale_pending();
        fg_sel = 2'd0;
        clear_watch();
        watch(45);
        tests++; if (w_starts !== 1 || w_mux[0] !== 2'd0) begin fails++; $display("FAIL fg0_frame: got %0d starts mux %0d want 1 mux 0", w_starts, w_mux[0]); end
        src_toggle[2] = ~src_toggle[2];
        clear_watch();
        watch(20);
        tests++; if (w_starts !== 0) begin fails++; $display("FAIL bg_toggle_no_frame: got %0d starts want 0", w_starts); end
        fg_sel = 2'd2;
        clear_watch();
        watch(80);
        tests++; if (w_starts !== 1) begin fails++; $display("FAIL fg2_starts: got %0d want 1", w_starts); end
        tests++; if (w_start[0] !== 2) begin fails++; $display("FAIL fg2_latency: got cycle %0d want 2", w_start[0]); end
        tests++; if (w_mux[0] !== 2'd2) begin fails++; $display("FAIL fg2_mux: got %0d want 2", w_mux[0]); end
        tests++; if (w_done !== 1) begin fails++; $display("FAIL fg2_done: got %0d want 1", w_done); end
    endtask

    task automatic test_overlay_abort();
        logic found;
        found = 1'b0;
        char_ready = 1'b1;
        src_toggle[2] = ~src_toggle[2];
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk_1k);
            if (char_valid && char_idx == 5'd10) found = 1'b1;
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL ovl_reach_idx10: got %0b want 1", found); end
        char_ready = 1'b0;
        ovl_req = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk_1k);
            tests++;
            if ({char_valid, char_idx, mux_sel} !== {1'b1, 5'd10, 2'd2}) begin
                fails++; $display("FAIL ovl_hold%0d: valid/idx/mux got %0b/%0d/%0d want 1/10/2", h, char_valid, char_idx, mux_sel);
            end
        end
        char_ready = 1'b1;
        @(negedge clk_1k);
        tests++; if ({char_valid, frame_done, frame_busy} !== 3'b000) begin fails++; $display("FAIL ovl_abort: valid,done,busy got %b want 000", {char_valid, frame_done, frame_busy}); end
        clear_watch();
        watch(45);
        tests++; if (w_starts !== 1 || w_start[0] !== 4) begin fails++; $display("FAIL ovl_redraw: got %0d starts at %0d want 1 at 4", w_starts, w_start[0]); end
        tests++; if (w_mux[0] !== 2'd3) begin fails++; $display("FAIL ovl_mux: got %0d want 3", w_mux[0]); end
        tests++; if (w_done !== 1 || w_valid !== 32) begin fails++; $display("FAIL ovl_frame: got done %0d valid %0d want 1 32", w_done, w_valid); end
        ovl_req = 1'b0;
        clear_watch();
        watch(45);
        tests++; if (w_starts !== 1 || w_mux[0] !== 2'd2) begin fails++; $display("FAIL ovl_release: got %0d starts mux %0d want 1 mux 2", w_starts, w_mux[0]); end
    endtask

    task automatic test_back_to_back();
        clear_watch();
        src_toggle[2] = ~src_toggle[2];
        watch(6);
        src_toggle[2] = ~src_toggle[2];
        watch(5);
        src_toggle[2] = ~src_toggle[2];
        watch(120);
        tests++; if (w_starts !== 2) begin fails++; $display("FAIL b2b_starts: got %0d want 2", w_starts); end
        tests++; if (w_start[0] !== 3) begin fails++; $display("FAIL b2b_latency: got cycle %0d want 3", w_start[0]); end
        tests++; if (w_start[1] !== w_first_done + 4) begin fails++; $display("FAIL b2b_spacing: got cycle %0d want %0d", w_start[1], w_first_done + 4); end
        tests++; if (w_done !== 2 || w_valid !== 64) begin fails++; $display("FAIL b2b_frames: got done %0d valid %0d want 2 64", w_done, w_valid); end
    endtask

    task automatic test_setup_collision();
        clear_watch();
        src_toggle[2] = ~src_toggle[2];
        watch(1);
        tests++; if (frame_busy !== 1'b0) begin fails++; $display("FAIL coll_idle: busy got %0b want 0", frame_busy); end
        watch(1);
        tests++; if ({frame_busy, char_valid} !== 2'b10) begin fails++; $display("FAIL coll_setup: busy,valid got %b want 10", {frame_busy, char_valid}); end
        src_toggle[2] = ~src_toggle[2];
        watch(120);
        tests++; if (w_starts !== 2) begin fails++; $display("FAIL coll_starts: got %0d want 2", w_starts); end
        tests++; if (w_start[1] !== w_first_done + 4) begin fails++; $display("FAIL coll_spacing: got cycle %0d want %0d", w_start[1], w_first_done + 4); end
        tests++; if (w_done !== 2) begin fails++; $display("FAIL coll_done: got %0d want 2", w_done); end
    endtask

    task automatic test_refresh();
        clear_watch();
        watch(1300);
        tests++; if (w_starts !== 2) begin fails++; $display("FAIL refresh_starts: got %0d want 2", w_starts); end
        tests++; if (w_start[1] - w_start[0] !== 534) begin fails++; $display("FAIL refresh_period: got %0d want 534", w_start[1] - w_start[0]); end
        tests++; if (w_mux[0] !== 2'd2 || w_mux[1] !== 2'd2) begin fails++; $display("FAIL refresh_mux: got %0d,%0d want 2,2", w_mux[0], w_mux[1]); end
        tests++; if (w_done !== 2) begin fails++; $display("FAIL refresh_done: got %0d want 2", w_done); end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_stale_pending();
        test_overlay_abort();
        test_back_to_back();
        test_setup_collision();
        test_refresh();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_frame_scheduler.md
# lcd_frame_scheduler

Sequences full-screen redraws of the 16x2 character LCD and shares it among the clock, stopwatch, timer and alarm controllers. It turns each source's update toggle (e.g. the stopwatch's `sw_update_toggle`) into a pending redraw request. It picks the source that owns the screen and steps the character mux and LCD driver through one 32-character frame using a valid/ready handshake. It also forces periodic refreshes, and redraws the screen when ownership changes.

## Interface
- `NSRC`, 4: number of display sources; `src_toggle` bit i belongs to source i.
- `NCHAR`, 32: characters per frame.
- `OVL_SRC`, 3: source index that takes the screen while `ovl_req` is high (alarm).
- `REFRESH_TICKS`, 500: idle ticks before a forced redraw; 0 disables refresh.
- `GAP_TICKS`, 2: idle ticks after every frame or abort.
- `clk_1k` in 1: system 1 kHz clock; one clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `src_toggle` in NSRC: per-source update toggle; any change is a redraw request.
- `fg_sel` in 2: foreground source chosen by the mode switches.
- `ovl_req` in 1: level; overrides `fg_sel` with `OVL_SRC`.
- `char_ready` in 1: LCD driver accepts the current character.
- `char_valid` out 1: character request to the LCD driver.
- `char_idx` out 5: position 0..31 (0–15 line 1, 16–31 line 2).
- `mux_sel` out 2: source whose character bus feeds the driver.
- `frame_busy` out 1: high in SETUP/SEND.
- `frame_done` out 1: one-cycle pulse when a frame completes (not on abort).

## Operation
- `eff = ovl_req ? OVL_SRC : fg_sel`, evaluated every cycle.
- Edge detect: `prev_tog` holds last cycle's `src_toggle`. If `src_toggle[i] != prev_tog[i]`, `pending[i]` is set.
- FSM states: IDLE, SETUP, SEND, GAP.
- IDLE → SETUP when any of these holds: `pending[eff]`; refresh due; no frame drawn since reset; `eff != last_src`.
- SETUP, one cycle:
  - latch `cur_src = eff`, `char_idx = 0`;
  - clear `pending[eff]` and the refresh counter;
  - discard `pending` of all other sources.
  - If an edge arrives in the same cycle, the set wins over the clear.
- SEND:
  - `char_valid = 1`.
  - `char_idx` and `mux_sel` stay stable until `char_ready`.
  - On accept: if idx = NCHAR-1, set `last_src = cur_src`, pulse `frame_done`, go to GAP; otherwise idx+1.
- Abort: if `eff != cur_src` during SEND, the outstanding character still completes its handshake. Then the FSM goes to GAP with no `frame_done` pulse. IDLE then redraws the new `eff`.
- Valid is never withdrawn before ready.
- GAP: counts GAP_TICKS cycles, then goes to IDLE.
- Refresh counter:
  - increments in IDLE and GAP, saturating at REFRESH_TICKS;
  - refresh is due when it equals REFRESH_TICKS (and REFRESH_TICKS ≠ 0);
  - cleared in SETUP.
- A toggle arriving during SEND/GAP for the current source stays pending and causes exactly one further frame.

## Timing
- Reset values:
  - state IDLE;
  - `char_valid`, `frame_busy`, `frame_done` = 0;
  - `char_idx`, `mux_sel` = 0;
  - `pending` = 0, `prev_tog` = 0;
  - "drawn" flag = 0, so the first frame starts right after reset.
- Reset mid-frame: `char_valid` drops asynchronously; the screen is redrawn after release.
- Latency, with a toggle change seen at edge k:
  - `pending` is set at k;
  - SETUP is entered at k+1;
  - `char_valid` is high from k+2.
- `char_ready` tied high:
  - frame = NCHAR cycles of valid;
  - `frame_done` is asserted in the first GAP cycle;
  - IDLE is reached GAP_TICKS cycles later.
- Request-to-next-frame minimum: 2 + NCHAR + GAP_TICKS cycles.

## Structure
- Package `lcd_sched_pkg`: state enum (IDLE/SETUP/SEND/GAP), `LCD_NCHAR = 32`, and source index constants `SRC_CLOCK = 0`, `SRC_STOPWATCH = 1`, `SRC_TIMER = 2`, `SRC_ALARM = 3`.
- Sub-module `lcd_refresh_timer`: saturating counter with a clear input and a `due` output.
- Edge detect and FSM live in the top module.

## Test plan
- Reset release with `fg_sel = 1`, `ready = 1` → 32 valid cycles, `mux_sel = 1`, idx 0..31, one `frame_done`, then 2 GAP cycles.
- `fg_sel = 0`, toggle src 2 → no frame. Then set `fg_sel = 2` → one frame with `mux_sel = 2`; the stale `pending[2]` gives no second frame.
- `ovl_req` rises at idx 10 while `char_ready` is low for 3 cycles → idx 10 is held until ready, then abort with no `frame_done`. After GAP, a frame with `mux_sel = 3`. When `ovl_req` falls, the `fg_sel` source is redrawn.
- Two toggles of the current source during SEND → exactly one extra frame.
- No toggles, REFRESH_TICKS = 500 → a new frame starts 500 idle/gap ticks after the previous SETUP clearing.
- Toggle and SETUP clear in the same cycle → pending stays set; a second frame follows.
